// File: rtl/dslave_write_arbiter_if.sv
// dslave_write_arbiter_if
//   Bundles the requester conduit signals and the Avalon-MM write-only
//   master signals of dslave_write_arbiter into one interface.
//
//   Parameter:
//     NREQ  number of requesters; must match the arbiter's NREQ.
//
//   Signals:
//     coe_req            [NREQ]    per-requester write request (level)
//     coe_wdata          [8*NREQ]  requester i data at [8i+7:8i]
//     coe_ack            [NREQ]    one-cycle pulse, write of requester i done
//     coe_err            [NREQ]    one-cycle pulse, write of requester i timed out
//     coe_busy                     high while a write is in progress or finishing
//     coe_grant_idx      [clog2]   current / last granted requester
//     avm_m0_writedata   [8]       write data to the slave
//     avm_m0_write                 write strobe to the slave
//     avm_m0_waitrequest           slave stall
//
//   Modports:
//     master  arbiter side (drives the Avalon master and conduit responses)
//     slave   environment side (requesters plus the Avalon slave)
interface dslave_write_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDXW = $clog2(NREQ);

  logic [NREQ-1:0]   coe_req;
  logic [8*NREQ-1:0] coe_wdata;
  logic [NREQ-1:0]   coe_ack;
  logic [NREQ-1:0]   coe_err;
  logic              coe_busy;
  logic [IDXW-1:0]   coe_grant_idx;
  logic [7:0]        avm_m0_writedata;
  logic              avm_m0_write;
  logic              avm_m0_waitrequest;

  modport master (
    input  coe_req, coe_wdata, avm_m0_waitrequest,
    output coe_ack, coe_err, coe_busy, coe_grant_idx,
    output avm_m0_writedata, avm_m0_write
  );

  modport slave (
    output coe_req, coe_wdata, avm_m0_waitrequest,
    input  coe_ack, coe_err, coe_busy, coe_grant_idx,
    input  avm_m0_writedata, avm_m0_write
  );
endinterface

// File: rtl/dslave_write_arbiter.sv
// dslave_write_arbiter
//   Shares one Avalon-MM write-only 8-bit slave port between NREQ
//   requesters. One requester is granted per decision, a single write is
//   run honouring waitrequest, and the requester gets a one-cycle ack on
//   completion or a one-cycle err if waitrequest stays high for TIMEOUT
//   consecutive edges. Every write takes at least IDLE -> WRITE -> DONE.
//
//   Parameters:
//     NREQ     number of requesters (2..8)
//     TIMEOUT  consecutive waitrequest-high edges before abort (1..255),
//              0 disables the timeout
//
//   Ports:
//     csi_clk      system clock, rising edge
//     rsi_reset_n  synchronous active-low reset
//     bus          dslave_write_arbiter_if.master (conduits + Avalon master)
//
//   Build option:
//     DSLAVE_ARB_RR_EN  defined: round-robin arbitration starting after the
//                       last winner; undefined: fixed priority, lowest index.
module dslave_write_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    csi_clk,
  input  logic                    rsi_reset_n,
  dslave_write_arbiter_if.master  bus
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic              busy_q, busy_d;
  logic [IDXW-1:0]   grant_q, grant_d;

  logic              found;
  logic [IDXW-1:0]   winner;

`ifdef DSLAVE_ARB_RR_EN
  logic [IDXW-1:0]   ptr_q, ptr_d;

  // Round-robin: search starts just after the last winner and wraps, so
  // the requester granted last time has the lowest priority now.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.coe_req[(int'(ptr_q) + k) % NREQ]) begin
        found  = 1'b1;
        winner = IDXW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end
`else
  // Fixed priority: scanning downward lets the lowest set index overwrite
  // any higher one, so requester 0 always wins when present.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.coe_req[i]) begin
        found  = 1'b1;
        winner = IDXW'(i);
      end
    end
  end
`endif

  // Next-state and next-output logic. ack/err default low so they only
  // ever last the single DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    err_d   = '0;
    busy_d  = busy_q;
    grant_d = grant_q;
`ifdef DSLAVE_ARB_RR_EN
    ptr_d   = ptr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          write_d = 1'b1;
          wdata_d = bus.coe_wdata[8*int'(winner) +: 8];
          busy_d  = 1'b1;
          grant_d = winner;
`ifdef DSLAVE_ARB_RR_EN
          ptr_d   = winner;
`endif
        end
      end

      ST_WRITE: begin
        if (!bus.avm_m0_waitrequest) begin
          state_d        = ST_DONE;
          write_d        = 1'b0;
          ack_d[grant_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          // The compare uses the incremented value so the abort lands on
          // the TIMEOUT-th consecutive stalled edge, not one later.
          if (TIMEOUT != 0 && ({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT)) begin
            state_d        = ST_DONE;
            write_d        = 1'b0;
            err_d[grant_q] = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state and outputs are registered; reset also aborts any write in
  // flight without reporting ack or err.
  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      grant_q <= '0;
`ifdef DSLAVE_ARB_RR_EN
      ptr_q   <= IDXW'(NREQ - 1);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
`ifdef DSLAVE_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.avm_m0_write     = write_q;
  assign bus.avm_m0_writedata = wdata_q;
  assign bus.coe_ack          = ack_q;
  assign bus.coe_err          = err_q;
  assign bus.coe_busy         = busy_q;
  assign bus.coe_grant_idx    = grant_q;

endmodule

// File: tb/tb_dslave_write_arbiter.sv
// tb_dslave_write_arbiter
//   Self-checking bench for dslave_write_arbiter with NREQ=4, TIMEOUT=8.
//   Expected grants come from a transaction-level arbitration function and
//   expected timing from the write/stall/timeout rules. Honours the
//   DSLAVE_ARB_RR_EN build option in its expectations.
module tb_dslave_write_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dslave_write_arbiter_if #(.NREQ(NREQ)) bus ();

  dslave_write_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .csi_clk     (clk),
    .rsi_reset_n (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int model_ptr;
  int last_idx;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    int          stalls;
    int          exp_idx;
    logic [7:0]  exp_data;
    bit          exp_ok;
  } vec_t;

  vec_t vecs[7];

  // Arbitration rule: round-robin from the pointer, or lowest index.
  function automatic int pickWinner(input logic [3:0] req, input int ptr);
`ifdef DSLAVE_ARB_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) return i;
    end
    if (ptr < 0) return -2;
`endif
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One complete write: grant, stalls, ack/err, return to idle.
  task automatic applyStimulus(input logic [3:0] req, input logic [31:0] wd, input int stalls,
                               input int exp_idx, input logic [7:0] exp_data, input bit exp_ok);
    int nw;
    logic [3:0] onehot;
    nw     = exp_ok ? stalls + 1 : TIMEOUT;
    onehot = 4'(1 << exp_idx);
    bus.coe_req            = req;
    bus.coe_wdata          = wd;
    bus.avm_m0_waitrequest = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("grant_write", 32'(bus.avm_m0_write), 32'd1);
    checkOutput("grant_data",  32'(bus.avm_m0_writedata), 32'(exp_data));
    checkOutput("grant_idx",   32'(bus.coe_grant_idx), 32'(exp_idx));
    checkOutput("grant_busy",  32'(bus.coe_busy), 32'd1);
    bus.coe_req = '0;
    for (int k = 1; k <= nw; k++) begin
      bus.coe_wdata          = $urandom;
      bus.avm_m0_waitrequest = (k <= stalls);
      @(posedge clk); @(negedge clk);
      if (k < nw) begin
        checkOutput("hold_write", 32'(bus.avm_m0_write), 32'd1);
        checkOutput("hold_data",  32'(bus.avm_m0_writedata), 32'(exp_data));
        checkOutput("hold_ack",   32'(bus.coe_ack), 32'd0);
        checkOutput("hold_err",   32'(bus.coe_err), 32'd0);
      end else begin
        checkOutput("done_write", 32'(bus.avm_m0_write), 32'd0);
        checkOutput("done_ack",   32'(bus.coe_ack), exp_ok ? 32'(onehot) : 32'd0);
        checkOutput("done_err",   32'(bus.coe_err), exp_ok ? 32'd0 : 32'(onehot));
        checkOutput("done_busy",  32'(bus.coe_busy), 32'd1);
      end
    end
    bus.avm_m0_waitrequest = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("idle_busy",  32'(bus.coe_busy), 32'd0);
    checkOutput("idle_ack",   32'(bus.coe_ack), 32'd0);
    checkOutput("idle_err",   32'(bus.coe_err), 32'd0);
    checkOutput("idle_write", 32'(bus.avm_m0_write), 32'd0);
    checkOutput("idle_grant", 32'(bus.coe_grant_idx), 32'(exp_idx));
    model_ptr = exp_idx;
    last_idx  = exp_idx;
  endtask

  task automatic idleCycle();
    bus.coe_req = '0;
    @(posedge clk); @(negedge clk);
    checkOutput("noreq_write", 32'(bus.avm_m0_write), 32'd0);
    checkOutput("noreq_busy",  32'(bus.coe_busy), 32'd0);
    checkOutput("noreq_grant", 32'(bus.coe_grant_idx), 32'(last_idx));
  endtask

  initial begin
    logic [3:0]  r;
    logic [31:0] wd;
    int          st;
    int          idx;
    logic [7:0]  dat;

    bus.coe_req            = '0;
    bus.coe_wdata          = '0;
    bus.avm_m0_waitrequest = 1'b0;
    rst_n                  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_write", 32'(bus.avm_m0_write), 32'd0);
    checkOutput("rst_data",  32'(bus.avm_m0_writedata), 32'd0);
    checkOutput("rst_ack",   32'(bus.coe_ack), 32'd0);
    checkOutput("rst_err",   32'(bus.coe_err), 32'd0);
    checkOutput("rst_busy",  32'(bus.coe_busy), 32'd0);
    checkOutput("rst_grant", 32'(bus.coe_grant_idx), 32'd0);
    rst_n     = 1'b1;
    model_ptr = NREQ - 1;
    last_idx  = 0;

    // Directed table; entries 4 and 5 differ between arbitration modes.
    vecs[0] = '{4'b0100, 32'h00A5_0000, 0, 2, 8'hA5, 1'b1};
    vecs[1] = '{4'b0001, 32'h1122_333C, 5, 0, 8'h3C, 1'b1};
    vecs[2] = '{4'b1000, 32'h7700_0000, 9, 3, 8'h77, 1'b0};
    vecs[3] = '{4'b0110, 32'h0022_1100, 2, 1, 8'h11, 1'b1};
`ifdef DSLAVE_ARB_RR_EN
    vecs[4] = '{4'b0110, 32'h5566_7788, 0, 2, 8'h66, 1'b1};
    vecs[5] = '{4'b1001, 32'h9A00_00BC, 8, 3, 8'h9A, 1'b0};
`else
    vecs[4] = '{4'b0110, 32'h5566_7788, 0, 1, 8'h77, 1'b1};
    vecs[5] = '{4'b1001, 32'h9A00_00BC, 8, 0, 8'hBC, 1'b0};
`endif
    vecs[6] = '{4'b1111, 32'hF1F2_F3F4, 7, 0, 8'hF4, 1'b1};

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].req, vecs[v].wdata, vecs[v].stalls,
                    vecs[v].exp_idx, vecs[v].exp_data, vecs[v].exp_ok);
    end
    idleCycle();

    // Contention: all requests held, zero-wait slave, one write per 3 cycles.
    bus.coe_req            = 4'hF;
    bus.coe_wdata          = 32'h4433_2211;
    bus.avm_m0_waitrequest = 1'b0;
    for (int g = 0; g < 5; g++) begin
      idx = pickWinner(4'hF, model_ptr);
      @(posedge clk); @(negedge clk);
      checkOutput("cont_write", 32'(bus.avm_m0_write), 32'd1);
      checkOutput("cont_grant", 32'(bus.coe_grant_idx), 32'(idx));
      checkOutput("cont_data",  32'(bus.avm_m0_writedata), 32'((idx + 1) * 8'h11));
      model_ptr = idx;
      @(posedge clk); @(negedge clk);
      checkOutput("cont_ack",   32'(bus.coe_ack), 32'(4'(1 << idx)));
      checkOutput("cont_wlow",  32'(bus.avm_m0_write), 32'd0);
      if (g == 4) bus.coe_req = '0;
      @(posedge clk); @(negedge clk);
      checkOutput("cont_idle",  32'(bus.coe_busy), 32'd0);
      checkOutput("cont_wgap",  32'(bus.avm_m0_write), 32'd0);
    end
    last_idx = model_ptr;
    idleCycle();

    // Reset in the middle of a stalled write.
    bus.coe_req            = 4'b0110;
    bus.coe_wdata          = 32'h00AB_CD00;
    bus.avm_m0_waitrequest = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("mid_write", 32'(bus.avm_m0_write), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("mid_rst_write", 32'(bus.avm_m0_write), 32'd0);
    checkOutput("mid_rst_ack",   32'(bus.coe_ack), 32'd0);
    checkOutput("mid_rst_err",   32'(bus.coe_err), 32'd0);
    checkOutput("mid_rst_busy",  32'(bus.coe_busy), 32'd0);
    checkOutput("mid_rst_grant", 32'(bus.coe_grant_idx), 32'd0);
    rst_n     = 1'b1;
    model_ptr = NREQ - 1;
    last_idx  = 0;
    applyStimulus(4'b0110, 32'h00AB_CD00, 0, 1, 8'hCD, 1'b1);

    // Randomized transactions against the arbitration/timeout rules.
    for (int n = 0; n < 40; n++) begin
      r = 4'($urandom_range(0, 15));
      if (r == 4'd0) begin
        idleCycle();
      end else begin
        st  = int'($urandom_range(0, 10));
        wd  = $urandom;
        idx = pickWinner(r, model_ptr);
        dat = wd[8*idx +: 8];
        applyStimulus(r, wd, st, idx, dat, st < TIMEOUT);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
